// File: rtl/rocc_cmd_issuer.sv
// Host-side RoCC command initiator: queues requests, issues them in order with at most one
// response outstanding, and reports latency, timeout and rd-mismatch per completion.
module rocc_cmd_issuer #(
   parameter int unsigned FIFO_DEPTH     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter int unsigned LAT_WIDTH      = 32
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 io_req_valid,
   output logic                 io_req_ready,
   input  logic [6:0]           io_req_funct,
   input  logic [4:0]           io_req_rd,
   input  logic                 io_req_xd,
   input  logic [63:0]          io_req_rs1,
   input  logic [63:0]          io_req_rs2,
   output logic                 io_cmd_valid,
   input  logic                 io_cmd_ready,
   output logic [6:0]           io_cmd_bits_inst_funct,
   output logic [4:0]           io_cmd_bits_inst_rd,
   output logic                 io_cmd_bits_inst_xd,
   output logic [6:0]           io_cmd_bits_inst_opcode,
   output logic [63:0]          io_cmd_bits_rs1,
   output logic [63:0]          io_cmd_bits_rs2,
   input  logic                 io_resp_valid,
   output logic                 io_resp_ready,
   input  logic [4:0]           io_resp_bits_rd,
   input  logic [63:0]          io_resp_bits_data,
   output logic                 io_done_valid,
   output logic [4:0]           io_done_rd,
   output logic [63:0]          io_done_data,
   output logic [LAT_WIDTH-1:0] io_done_latency,
   output logic [1:0]           io_done_err,
   output logic                 io_busy,
   output logic [15:0]          io_spurious_cnt
);

   localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CntW = PtrW + 1;
   localparam logic [LAT_WIDTH-1:0] TimeoutLat = LAT_WIDTH'(TIMEOUT_CYCLES);

   typedef struct packed {
      logic [6:0]  funct;
      logic [4:0]  rd;
      logic        xd;
      logic [63:0] rs1;
      logic [63:0] rs2;
   } req_t;

   typedef enum logic [1:0] {StIdle, StIssue, StWaitResp, StReport} state_e;

   state_e state_q, state_d;

   // Request queue
   req_t            fifo_q [FIFO_DEPTH];
   logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0] count_q, count_d;
   logic            full, empty, push, pop;

   // Issued command
   logic [6:0]  cmd_funct_q;
   logic [4:0]  cmd_rd_q;
   logic        cmd_xd_q;
   logic [63:0] cmd_rs1_q, cmd_rs2_q;

   // Completion record and bookkeeping
   logic [LAT_WIDTH-1:0] lat_q;
   logic [4:0]           done_rd_q;
   logic [63:0]          done_data_q;
   logic [LAT_WIDTH-1:0] done_lat_q;
   logic [1:0]           done_err_q;
   logic [15:0]          spur_q;
   logic                 active_q;

   logic cmd_fire, resp_fire, resp_spur, timeout, load_cmd;

   assign full      = (count_q == CntW'(FIFO_DEPTH));
   assign empty     = (count_q == '0);
   assign push      = io_req_valid && io_req_ready;
   assign cmd_fire  = (state_q == StIssue) && io_cmd_ready;
   assign pop       = cmd_fire;
   assign load_cmd  = (state_q == StIdle) && !empty;
   assign resp_fire = io_resp_valid && active_q && (state_q == StWaitResp);
   assign resp_spur = io_resp_valid && active_q && (state_q != StWaitResp);
   assign timeout   = (lat_q == TimeoutLat);

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock) begin
      if (push) begin
         fifo_q[wr_ptr_q] <= '{funct: io_req_funct, rd: io_req_rd, xd: io_req_xd,
                                rs1: io_req_rs1, rs2: io_req_rs2};
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         active_q <= 1'b0;
      end else begin
         active_q <= 1'b1;
         count_q  <= count_d;
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   // FSM: state register
   always_ff @(posedge clock) begin
      if (reset) state_q <= StIdle;
      else       state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:     if (!empty) state_d = StIssue;
         StIssue:    if (io_cmd_ready) state_d = cmd_xd_q ? StWaitResp : StIdle;
         StWaitResp: if (resp_fire || timeout) state_d = StReport;
         StReport:   state_d = StIdle;
         default:    state_d = StIdle;
      endcase
   end

   // FSM: outputs
   always_comb begin
      io_cmd_valid  = (state_q == StIssue);
      io_done_valid = (state_q == StReport);
      io_busy       = (state_q != StIdle) || !empty;
   end

   // Command bits are latched once in IDLE so they stay stable for the whole ISSUE stall
   always_ff @(posedge clock) begin
      if (reset) begin
         cmd_funct_q <= '0;
         cmd_rd_q    <= '0;
         cmd_xd_q    <= 1'b0;
         cmd_rs1_q   <= '0;
         cmd_rs2_q   <= '0;
      end else if (load_cmd) begin
         cmd_funct_q <= fifo_q[rd_ptr_q].funct;
         cmd_rd_q    <= fifo_q[rd_ptr_q].rd;
         cmd_xd_q    <= fifo_q[rd_ptr_q].xd;
         cmd_rs1_q   <= fifo_q[rd_ptr_q].rs1;
         cmd_rs2_q   <= fifo_q[rd_ptr_q].rs2;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         lat_q <= '0;
      end else if (cmd_fire && cmd_xd_q) begin
         lat_q <= LAT_WIDTH'(1);
      end else if ((state_q == StWaitResp) && !resp_fire && !timeout && (lat_q != '1)) begin
         lat_q <= lat_q + 1'b1;
      end
   end

   // A response coinciding with the timeout cycle takes priority
   always_ff @(posedge clock) begin
      if (reset) begin
         done_rd_q   <= '0;
         done_data_q <= '0;
         done_lat_q  <= '0;
         done_err_q  <= '0;
      end else if (resp_fire) begin
         done_rd_q   <= cmd_rd_q;
         done_data_q <= io_resp_bits_data;
         done_lat_q  <= lat_q;
         done_err_q  <= (io_resp_bits_rd != cmd_rd_q) ? 2'b10 : 2'b00;
      end else if ((state_q == StWaitResp) && timeout) begin
         done_rd_q   <= cmd_rd_q;
         done_data_q <= '0;
         done_lat_q  <= TimeoutLat;
         done_err_q  <= 2'b01;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         spur_q <= '0;
      end else if (resp_spur && (spur_q != 16'hFFFF)) begin
         spur_q <= spur_q + 16'd1;
      end
   end

   assign io_req_ready            = active_q && !full;
   assign io_resp_ready           = active_q;
   assign io_cmd_bits_inst_funct  = cmd_funct_q;
   assign io_cmd_bits_inst_rd     = cmd_rd_q;
   assign io_cmd_bits_inst_xd     = cmd_xd_q;
   assign io_cmd_bits_inst_opcode = 7'h0B;
   assign io_cmd_bits_rs1         = cmd_rs1_q;
   assign io_cmd_bits_rs2         = cmd_rs2_q;
   assign io_done_rd              = done_rd_q;
   assign io_done_data            = done_data_q;
   assign io_done_latency         = done_lat_q;
   assign io_done_err             = done_err_q;
   assign io_spurious_cnt         = spur_q;

   cmd_stable_a: assert property (@(posedge clock) disable iff (reset)
      io_cmd_valid && !io_cmd_ready |=> io_cmd_valid && $stable(io_cmd_bits_rs1)
                                        && $stable(io_cmd_bits_inst_funct));

   done_pulse_a: assert property (@(posedge clock) disable iff (reset)
      io_done_valid |=> !io_done_valid);

endmodule

// File: tb/tb_rocc_cmd_issuer.sv
// Directed bench for rocc_cmd_issuer: table of single-command transactions plus hand-written
// sequences for queue back-pressure, post-timeout responses and mid-flight reset.
module tb_rocc_cmd_issuer;

   logic        clock = 1'b0;
   logic        reset;
   logic        io_req_valid, io_req_ready, io_req_xd;
   logic [6:0]  io_req_funct;
   logic [4:0]  io_req_rd;
   logic [63:0] io_req_rs1, io_req_rs2;
   logic        io_cmd_valid, io_cmd_ready;
   logic [6:0]  io_cmd_bits_inst_funct, io_cmd_bits_inst_opcode;
   logic [4:0]  io_cmd_bits_inst_rd;
   logic        io_cmd_bits_inst_xd;
   logic [63:0] io_cmd_bits_rs1, io_cmd_bits_rs2;
   logic        io_resp_valid, io_resp_ready;
   logic [4:0]  io_resp_bits_rd;
   logic [63:0] io_resp_bits_data;
   logic        io_done_valid;
   logic [4:0]  io_done_rd;
   logic [63:0] io_done_data;
   logic [31:0] io_done_latency;
   logic [1:0]  io_done_err;
   logic        io_busy;
   logic [15:0] io_spurious_cnt;

   int n_vec = 0;
   int n_bad = 0;

   rocc_cmd_issuer #(
      .FIFO_DEPTH    (4),
      .TIMEOUT_CYCLES(16),
      .LAT_WIDTH     (32)
   ) dut (
      .clock                  (clock),
      .reset                  (reset),
      .io_req_valid           (io_req_valid),
      .io_req_ready           (io_req_ready),
      .io_req_funct           (io_req_funct),
      .io_req_rd              (io_req_rd),
      .io_req_xd              (io_req_xd),
      .io_req_rs1             (io_req_rs1),
      .io_req_rs2             (io_req_rs2),
      .io_cmd_valid           (io_cmd_valid),
      .io_cmd_ready           (io_cmd_ready),
      .io_cmd_bits_inst_funct (io_cmd_bits_inst_funct),
      .io_cmd_bits_inst_rd    (io_cmd_bits_inst_rd),
      .io_cmd_bits_inst_xd    (io_cmd_bits_inst_xd),
      .io_cmd_bits_inst_opcode(io_cmd_bits_inst_opcode),
      .io_cmd_bits_rs1        (io_cmd_bits_rs1),
      .io_cmd_bits_rs2        (io_cmd_bits_rs2),
      .io_resp_valid          (io_resp_valid),
      .io_resp_ready          (io_resp_ready),
      .io_resp_bits_rd        (io_resp_bits_rd),
      .io_resp_bits_data      (io_resp_bits_data),
      .io_done_valid          (io_done_valid),
      .io_done_rd             (io_done_rd),
      .io_done_data           (io_done_data),
      .io_done_latency        (io_done_latency),
      .io_done_err            (io_done_err),
      .io_busy                (io_busy),
      .io_spurious_cnt        (io_spurious_cnt)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [6:0]  funct;
      logic [4:0]  rd;
      logic        xd;
      logic [63:0] rs1;
      logic [63:0] rs2;
      logic        resp_en;
      int          dly;        // response cycle, counted from the handshake edge
      logic [4:0]  resp_rd;
      logic [63:0] resp_data;
      int          exp_done_c; // cycle of the done pulse after handshake, 0 = none
      logic [63:0] exp_data;
      logic [31:0] exp_lat;
      logic [1:0]  exp_err;
   } txn_t;

   txn_t vec [6];

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " req_ready"}, io_req_ready, 0);
      check({tag, " resp_ready"}, io_resp_ready, 0);
      check({tag, " cmd_valid"}, io_cmd_valid, 0);
      check({tag, " cmd_funct"}, io_cmd_bits_inst_funct, 0);
      check({tag, " cmd_rd"}, io_cmd_bits_inst_rd, 0);
      check({tag, " cmd_rs1"}, io_cmd_bits_rs1, 0);
      check({tag, " opcode"}, io_cmd_bits_inst_opcode, 64'h0B);
      check({tag, " done_valid"}, io_done_valid, 0);
      check({tag, " done_rd"}, io_done_rd, 0);
      check({tag, " done_data"}, io_done_data, 0);
      check({tag, " done_lat"}, io_done_latency, 0);
      check({tag, " done_err"}, io_done_err, 0);
      check({tag, " busy"}, io_busy, 0);
      check({tag, " spurious"}, io_spurious_cnt, 0);
   endtask

   task automatic run_txn(input int idx, input txn_t t);
      int n_done = 0;
      int done_c = 0;
      string tg;
      tg = $sformatf("v%0d", idx);
      io_cmd_ready = 1'b0;
      check({tg, " req_ready"}, io_req_ready, 1);
      io_req_valid = 1'b1;
      io_req_funct = t.funct;
      io_req_rd    = t.rd;
      io_req_xd    = t.xd;
      io_req_rs1   = t.rs1;
      io_req_rs2   = t.rs2;
      step();
      io_req_valid = 1'b0;
      check({tg, " cmd_valid N+1"}, io_cmd_valid, 0);
      step();
      check({tg, " cmd_valid N+2"}, io_cmd_valid, 1);
      check({tg, " cmd_funct"}, io_cmd_bits_inst_funct, t.funct);
      check({tg, " cmd_rd"}, io_cmd_bits_inst_rd, t.rd);
      check({tg, " cmd_xd"}, io_cmd_bits_inst_xd, t.xd);
      check({tg, " cmd_rs1"}, io_cmd_bits_rs1, t.rs1);
      check({tg, " cmd_rs2"}, io_cmd_bits_rs2, t.rs2);
      check({tg, " opcode"}, io_cmd_bits_inst_opcode, 64'h0B);
      io_cmd_ready = 1'b1;
      step();
      io_cmd_ready = 1'b0;
      for (int c = 1; c <= 24; c++) begin
         if (io_done_valid) begin
            n_done++;
            done_c = c;
         end
         if (!t.xd && c == 2) check({tg, " busy idle"}, io_busy, 0);
         io_resp_valid     = t.resp_en && (c == t.dly);
         io_resp_bits_rd   = t.resp_rd;
         io_resp_bits_data = t.resp_data;
         step();
      end
      io_resp_valid = 1'b0;
      check({tg, " done count"}, 64'(n_done), (t.exp_done_c != 0) ? 64'd1 : 64'd0);
      if (t.exp_done_c != 0) begin
         check({tg, " done cycle"}, 64'(done_c), 64'(t.exp_done_c));
         check({tg, " done_rd"}, io_done_rd, t.rd);
         check({tg, " done_data"}, io_done_data, t.exp_data);
         check({tg, " done_lat"}, io_done_latency, t.exp_lat);
         check({tg, " done_err"}, io_done_err, t.exp_err);
      end
      check({tg, " spurious"}, io_spurious_cnt, 0);
   endtask

   initial begin
      int   hs;
      int   n_done;
      logic seen;
      logic [63:0] got [4];

      // funct rd xd rs1 rs2 | resp_en dly resp_rd resp_data | done_c data lat err
      vec[0] = '{7'd2, 5'd5, 1'b1, 64'h10, 64'h0, 1'b1, 4, 5'd5, 64'd6, 5, 64'd6, 32'd4, 2'b00};
      vec[1] = '{7'h11, 5'd3, 1'b0, 64'hDEAD_BEEF_0000_0001, 64'h1234_5678_9ABC_DEF0,
                 1'b0, 0, 5'd0, 64'd0, 0, 64'd0, 32'd0, 2'b00};
      vec[2] = '{7'd4, 5'd5, 1'b1, 64'h20, 64'h1, 1'b1, 2, 5'd7, 64'hAB, 3, 64'hAB, 32'd2, 2'b10};
      vec[3] = '{7'd1, 5'd9, 1'b1, 64'h30, 64'h2, 1'b1, 1, 5'd9, 64'hFFFF_FFFF_FFFF_FFFF,
                 2, 64'hFFFF_FFFF_FFFF_FFFF, 32'd1, 2'b00};
      vec[4] = '{7'd3, 5'd12, 1'b1, 64'h40, 64'h3, 1'b1, 16, 5'd12, 64'h55,
                 17, 64'h55, 32'd16, 2'b00};
      vec[5] = '{7'd3, 5'd12, 1'b1, 64'h50, 64'h4, 1'b0, 0, 5'd0, 64'd0,
                 17, 64'd0, 32'd16, 2'b01};

      reset = 1'b1;
      io_req_valid = 1'b0; io_req_funct = '0; io_req_rd = '0; io_req_xd = 1'b0;
      io_req_rs1 = '0; io_req_rs2 = '0; io_cmd_ready = 1'b0;
      io_resp_valid = 1'b0; io_resp_bits_rd = '0; io_resp_bits_data = '0;
      repeat (3) step();
      reset = 1'b0;
      check_reset_outputs("reset");
      step();
      check("resp_ready after reset", io_resp_ready, 1);

      for (int i = 0; i < 6; i++) run_txn(i, vec[i]);

      // Late response after the timeout: counted as spurious, no completion
      io_resp_valid = 1'b1; io_resp_bits_rd = 5'd12; io_resp_bits_data = 64'h77;
      step();
      io_resp_valid = 1'b0;
      n_done = 0;
      for (int c = 0; c < 4; c++) begin
         if (io_done_valid) n_done++;
         step();
      end
      check("late resp spurious", io_spurious_cnt, 1);
      check("late resp no done", 64'(n_done), 0);

      // Back-pressure: queue fills while the accelerator stalls
      io_cmd_ready = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         check($sformatf("fill req_ready %0d", i), io_req_ready, (i <= 4) ? 64'd1 : 64'd0);
         io_req_valid = 1'b1;
         io_req_funct = 7'(i); io_req_rd = 5'(i); io_req_xd = 1'b0;
         io_req_rs1 = 64'(i); io_req_rs2 = 64'(i * 16);
         step();
      end
      io_req_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         check("stall cmd_valid", io_cmd_valid, 1);
         check("stall rs1", io_cmd_bits_rs1, 1);
         check("stall funct", io_cmd_bits_inst_funct, 1);
         step();
      end
      io_cmd_ready = 1'b1;
      hs = 0;
      for (int c = 0; c < 30; c++) begin
         if (io_cmd_valid && io_cmd_ready) begin
            if (hs < 4) got[hs] = io_cmd_bits_rs1;
            hs++;
         end
         step();
      end
      io_cmd_ready = 1'b0;
      check("drain handshakes", 64'(hs), 4);
      for (int i = 0; i < 4; i++)
         if (i < hs) check($sformatf("drain order %0d", i), got[i], 64'(i + 1));
      check("drain busy", io_busy, 0);

      // Reset while waiting for a response
      io_req_valid = 1'b1; io_req_funct = 7'd2; io_req_rd = 5'd5; io_req_xd = 1'b1;
      io_req_rs1 = 64'h99; io_req_rs2 = 64'h0;
      io_cmd_ready = 1'b1;
      step();
      io_req_valid = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 6 && !seen; c++) begin
         if (io_cmd_valid) seen = 1'b1;
         step();
      end
      io_cmd_ready = 1'b0;
      check("rst seq cmd issued", seen, 1);
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check_reset_outputs("midrst");
      step();
      io_resp_valid = 1'b1; io_resp_bits_rd = 5'd5; io_resp_bits_data = 64'h1;
      step();
      io_resp_valid = 1'b0;
      n_done = 0;
      for (int c = 0; c < 4; c++) begin
         if (io_done_valid) n_done++;
         step();
      end
      check("post-reset spurious", io_spurious_cnt, 1);
      check("post-reset no done", 64'(n_done), 0);
      check("post-reset busy", io_busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/rocc_cmd_issuer.md
Name: rocc_cmd_issuer

Overview:
- Host-side initiator of the RoCC command/response interface. It drives custom-instruction commands into an accelerator and collects the responses.
- It queues requests from a test/driver source and issues them in order, with at most one response-bearing command outstanding.
- It measures per-command response latency, detects timeouts and rd mismatches, and reports each completion as a single-cycle record.
- It sits in place of the core's RoCC port for accelerator bring-up and latency characterisation.

Parameters:
- FIFO_DEPTH, 4: request queue entries (power of two, ≥2).
- TIMEOUT_CYCLES, 1024: maximum wait for a response, in cycles after command handshake.
- LAT_WIDTH, 32: width of the latency counter and the reported latency.

Ports:
- clock  in  1  single clock.
- reset  in  1  synchronous, active-high.
- io_req_valid  in  1  request enqueue valid.
- io_req_ready  out  1  queue not full.
- io_req_funct  in  7  funct field.
- io_req_rd  in  5  destination register.
- io_req_xd  in  1  command expects a response.
- io_req_rs1  in  64  operand 1.
- io_req_rs2  in  64  operand 2.
- io_cmd_valid  out  1  command valid to accelerator.
- io_cmd_ready  in  1  accelerator accepts command.
- io_cmd_bits_inst_funct  out  7  funct field.
- io_cmd_bits_inst_rd  out  5  destination register.
- io_cmd_bits_inst_xd  out  1  xd bit.
- io_cmd_bits_inst_opcode  out  7  constant 7'h0B (custom-0).
- io_cmd_bits_rs1  out  64  operand 1.
- io_cmd_bits_rs2  out  64  operand 2.
- io_resp_valid  in  1  accelerator response valid.
- io_resp_ready  out  1  constant 1 out of reset.
- io_resp_bits_rd  in  5  response rd.
- io_resp_bits_data  in  64  response data.
- io_done_valid  out  1  one-cycle completion pulse.
- io_done_rd  out  5  rd of the issued command.
- io_done_data  out  64  response data (0 on timeout).
- io_done_latency  out  LAT_WIDTH  cycles from command handshake to response handshake.
- io_done_err  out  2  00 ok, 01 timeout, 10 rd mismatch.
- io_busy  out  1  state != IDLE or queue non-empty.
- io_spurious_cnt  out  16  saturating count of unexpected responses.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE; the queue is emptied; all counters clear.
  - All outputs read 0 except io_cmd_bits_inst_opcode (7'h0B). io_resp_ready is 0 during reset and 1 thereafter.
  - Reset mid-operation abandons any in-flight command with no done pulse. A response arriving after reset counts as spurious.
- Queue:
  - In-order FIFO.
  - io_req_ready = !full, based on registered occupancy only. A full queue refuses enqueue even if a pop occurs the same cycle.
  - Enqueue at cycle N: IDLE sees non-empty at N+1, and io_cmd_valid asserts at N+2.
- FSM states: IDLE, ISSUE, WAIT_RESP, REPORT.
- IDLE:
  - If the queue is non-empty, register the head into the cmd outputs and go to ISSUE.
- ISSUE:
  - io_cmd_valid=1.
  - All cmd bits stay stable until io_cmd_valid && io_cmd_ready.
  - On handshake: pop the queue.
    - xd=1: go to WAIT_RESP with the latency counter set to 1.
    - xd=0: go to IDLE with no done pulse.
  - io_cmd_valid never drops without a handshake.
- WAIT_RESP:
  - On response handshake: capture data, set latency to the counter value, set err=10 if resp rd != issued rd (else 00), then go to REPORT.
  - Else if counter == TIMEOUT_CYCLES: err=01, data=0, latency=TIMEOUT_CYCLES, go to REPORT.
  - Else counter increments.
  - A response in the same cycle as the timeout condition wins, giving err=00 or 10.
  - A response in the first WAIT_RESP cycle reports latency 1.
- REPORT:
  - io_done_valid=1 for exactly one cycle, then go to IDLE.
  - The done fields hold their values until the next REPORT.
- Spurious responses:
  - Any io_resp_valid while the state is not WAIT_RESP (IDLE, ISSUE, REPORT) is accepted and dropped.
  - Each one increments io_spurious_cnt, saturating at 16'hFFFF.
  - Late responses after a timeout are counted here.
- Latency counter: saturates at all-ones.
- Back-to-back issue: the earliest next io_cmd_valid is 2 cycles after the previous xd=0 handshake (ISSUE→IDLE→ISSUE).

Test Plan:
- Enqueue funct=2, rd=5, xd=1, rs1=0x10; accelerator raises cmd_ready at the first valid and responds rd=5, data=6 4 cycles after the handshake → single done pulse, rd=5, data=6, latency=4, err=00.
- Enqueue xd=0 command → one cmd handshake with correct rs1/rs2, no done pulse, io_busy low 2 cycles later.
- Hold cmd_ready=0; enqueue rs1=1..5 with FIFO_DEPTH=4 → 5th request sees io_req_ready=0; release cmd_ready → commands issue in order with rs1=1,2,3,4, and bits stay stable while stalled.
- TIMEOUT_CYCLES=16, no response → done err=01, latency=16, data=0; a response 3 cycles later → io_spurious_cnt=1 and no done pulse.
- Response rd=7 for an issued rd=5, data=0xAB → done err=10, rd=5, data=0xAB.
- Assert reset for one cycle during WAIT_RESP → next cycle all outputs are 0, queue empty, state IDLE; a following response increments io_spurious_cnt to 1.
